mult_result_checker: RTL
========================

Name: mult_result_checker

Overview:
- Response-side counterpart to the 8x8 multiplier stimulus path. Sits beside the multiplier and watches the operands going into the DUT and the product coming out.
- Computes the expected product, compares it with the DUT result after a fixed latency, and reports the outcome: vector count, error count, details of the first failure, and a final pass/done status.
- Synthesizable, so the on-board self-check replaces offline dump comparison.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH
LATENCY, 2, cycles from operand acceptance to valid p; legal range 1..8
NUM_VECTORS, 50000, vectors to check per run
COUNT_W, 16, width of the vector/error/index counters; must satisfy 2^COUNT_W > NUM_VECTORS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  a/b presented to DUT this cycle
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
p  input  2*WIDTH  DUT product
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE
pass  output  1  done && err_count==0
mismatch  output  1  one-cycle pulse per failing compare
vec_count  output  COUNT_W  vectors compared so far
err_count  output  COUNT_W  mismatches so far; saturates at all-ones
first_err_idx  output  COUNT_W  index of first failing vector
first_err_exp  output  2*WIDTH  expected value at first failure
first_err_got  output  2*WIDTH  DUT value at first failure

Behaviour:
- Reset: state IDLE; all outputs 0; delay line valid bits cleared; in-flight vectors discarded. A reset mid-run aborts the run with no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; counters and first_err_* cleared.
  - RUN: accepts in_valid vectors. The acceptance that reaches NUM_VECTORS accepted -> DRAIN.
  - DRAIN: in_valid ignored. Stays until the delay line holds no valid entries and the last compare has completed -> DONE.
  - DONE: holds results. start -> RUN with counters cleared.
  - start in RUN or DRAIN is ignored. in_valid in IDLE or DONE is ignored.
- Acceptance: in_valid in RUN loads stage 0 of a LATENCY-deep shift register with {valid=1, exp=a*b (unsigned, full 2*WIDTH), idx=accept counter}. A new entry may enter every cycle (throughput 1).
- Compare: the tail entry of a vector accepted at cycle t is valid at cycle t+LATENCY; p is sampled that same cycle.
- Results of a compare are registered and visible in the next cycle:
  - vec_count increments.
  - On mismatch: mismatch pulses, err_count increments (held at all-ones if saturated).
  - On the first mismatch only (err_count was 0): first_err_idx/exp/got are captured.
- Index numbering starts at 0 per run.
- Gaps in in_valid are allowed; compares occur only for valid tail entries.
- done and busy are mutually exclusive. pass is valid only while done=1 and is 0 otherwise.
- Transition DRAIN->DONE occurs in the cycle after the final compare's counters update, so vec_count==NUM_VECTORS is visible when done rises.

Test Plan:
1. NUM_VECTORS=4, LATENCY=2, ideal DUT model; vectors (3,5),(255,255),(0,77),(16,16) back-to-back -> vec_count=4, err_count=0, done=1, pass=1, mismatch never asserted.
2. Same vectors, DUT forces p=0x0001 for vector 1 only -> err_count=1, first_err_idx=1, first_err_exp=0xFE01, first_err_got=0x0001, one mismatch pulse at cycle t1+LATENCY+1, pass=0.
3. Vectors with in_valid gaps (valid on cycles 0,3,4,9) -> exactly 4 compares at cycles 2,5,6,11; results identical to scenario 1.
4. Assert rst while busy after 2 of 4 vectors -> next cycle all outputs 0, state IDLE; a subsequent start plus 4 vectors completes normally with vec_count=4.
5. Extra in_valid after the 4th accepted vector, plus start pulses during DRAIN -> ignored; vec_count=4; done rises once.
6. COUNT_W=3, NUM_VECTORS=7, every compare wrong -> err_count saturates at 7 (no wrap), first_err_idx=0; then start from DONE -> counters cleared, busy=1.

Source files
------------

// File: rtl/mult_result_checker_if.sv
// -----------------------------------------------------------------------------
// mult_result_checker_if
//   Groups the signals the checker observes around an 8x8 (WIDTH x WIDTH)
//   multiplier: the run-control pulse, the operand stream entering the
//   multiplier and the product leaving it.
//
//   Signals:
//     start     single-cycle pulse that begins a checking run
//     in_valid  a/b are presented to the multiplier this cycle
//     a, b      unsigned operands, WIDTH bits each
//     p         multiplier product, 2*WIDTH bits
//
//   Modports:
//     master    the side that produces the stream (stimulus + multiplier)
//     slave     the checker, which only observes
// -----------------------------------------------------------------------------
interface mult_result_checker_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               in_valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;

    modport master (output start, in_valid, a, b, p);
    modport slave  (input  start, in_valid, a, b, p);
endinterface

// File: rtl/mult_result_checker.sv
// -----------------------------------------------------------------------------
// mult_result_checker
//   On-board response checker for a fixed-latency unsigned multiplier.
//   Every operand pair accepted during a run is multiplied locally and pushed
//   into a LATENCY-deep delay line. When an entry reaches the tail it lines up
//   with the multiplier's product, the two are compared, and the outcome is
//   folded into the run statistics. A run covers NUM_VECTORS operand pairs.
//
//   Ports:
//     clk            system clock, rising edge
//     rst            synchronous, active-high reset
//     bus            mult_result_checker_if.slave (start, in_valid, a, b, p)
//     busy           run in progress (RUN or DRAIN)
//     done           run finished, results held
//     pass           done with zero mismatches
//     mismatch       one-cycle pulse per failing compare
//     vec_count      vectors compared so far in this run
//     err_count      mismatches so far; saturates at all-ones
//     first_err_idx  index of the first failing vector (0-based per run)
//     first_err_exp  expected product at the first failure
//     first_err_got  observed product at the first failure
// -----------------------------------------------------------------------------
module mult_result_checker #(
    parameter int WIDTH       = 8,
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 50000,
    parameter int COUNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mult_result_checker_if.slave     bus,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     mismatch,
    output logic [COUNT_W-1:0]       vec_count,
    output logic [COUNT_W-1:0]       err_count,
    output logic [COUNT_W-1:0]       first_err_idx,
    output logic [2*WIDTH-1:0]       first_err_exp,
    output logic [2*WIDTH-1:0]       first_err_got
);

    localparam int                 EXP_W    = 2 * WIDTH;
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_VECTORS - 1);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("mult_result_checker: LATENCY must be 1..8");
    end
    if ((64'(1) << COUNT_W) <= 64'(NUM_VECTORS)) begin : g_bad_count_w
        $error("mult_result_checker: COUNT_W too narrow for NUM_VECTORS");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One in-flight vector: expected product and its index within the run.
    typedef struct packed {
        logic               valid;
        logic [EXP_W-1:0]   exp;
        logic [COUNT_W-1:0] idx;
    } entry_t;

    state_t                    state_q, state_d;
    entry_t [LATENCY-1:0]      pipe_q, pipe_d;
    logic   [COUNT_W-1:0]      acc_cnt_q, acc_cnt_d;
    logic   [COUNT_W-1:0]      vec_cnt_q, vec_cnt_d;
    logic   [COUNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic   [COUNT_W-1:0]      fe_idx_q, fe_idx_d;
    logic   [EXP_W-1:0]        fe_exp_q, fe_exp_d;
    logic   [EXP_W-1:0]        fe_got_q, fe_got_d;
    logic                      mismatch_q, mismatch_d;

    logic   accept;
    logic   any_valid;
    entry_t tail;
    logic   cmp_bad;

    // -------------------------------------------------------------------------
    // Next-state logic: delay line, compare bookkeeping and run FSM.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        fe_idx_d   = fe_idx_q;
        fe_exp_d   = fe_exp_q;
        fe_got_d   = fe_got_q;
        mismatch_d = 1'b0;
        any_valid  = 1'b0;

        accept  = (state_q == S_RUN) && bus.in_valid;
        tail    = pipe_q[LATENCY-1];
        cmp_bad = (tail.exp != bus.p);

        // Delay line shifts every cycle; stage 0 only carries a valid entry
        // when a vector is accepted, so gaps become bubbles that never compare.
        pipe_d[0] = '{valid: accept,
                      exp:   EXP_W'(bus.a) * EXP_W'(bus.b),
                      idx:   acc_cnt_q};
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | pipe_q[i].valid;
        end

        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_ONE;
        end

        // The tail entry lines up with this cycle's product.
        if (tail.valid) begin
            vec_cnt_d = vec_cnt_q + CNT_ONE;
            if (cmp_bad) begin
                mismatch_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
                if (err_cnt_q == '0) begin
                    fe_idx_d = tail.idx;
                    fe_exp_d = tail.exp;
                    fe_got_d = bus.p;
                end
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // The delay line is empty here, so clearing cannot drop a
                // pending compare.
                if (bus.start) begin
                    state_d   = S_RUN;
                    acc_cnt_d = '0;
                    vec_cnt_d = '0;
                    err_cnt_d = '0;
                    fe_idx_d  = '0;
                    fe_exp_d  = '0;
                    fe_got_d  = '0;
                end
            end
            S_RUN: begin
                if (accept && (acc_cnt_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // An empty line means the final compare has already been
                // registered, so vec_count is complete when done rises.
                if (!any_valid) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and statistics registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_got_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fe_idx_q   <= fe_idx_d;
            fe_exp_q   <= fe_exp_d;
            fe_got_q   <= fe_got_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Delay line.
    always_ff @(posedge clk) begin
        // NOTE: only the valid bits are reset; payload is never looked at
        // while its valid bit is low, so it needs no reset.
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_cnt_q == '0);
    assign mismatch      = mismatch_q;
    assign vec_count     = vec_cnt_q;
    assign err_count     = err_cnt_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;

endmodule
